// File: rtl/sliding_window_threshold_detector.sv
// k-of-N threshold detector over a sliding window of 1-bit samples.
// Registered count, full and detect; one cycle of latency per accepted sample.
module sliding_window_threshold_detector #(
    parameter int p_depth = 3,
    parameter int p_thresh = 2,
    parameter bit p_require_full = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_val,
    input  logic                         in_bit,
    input  logic                         clear,
    output logic [$clog2(p_depth+1)-1:0] count,
    output logic                         full,
    output logic                         detect
);

    localparam int cw = $clog2(p_depth + 1);
    localparam logic [cw-1:0] depth_c = cw'(p_depth);
    localparam logic [cw-1:0] thresh_c = cw'(p_thresh);

    if (p_depth < 1 || p_depth > 64) begin : g_bad_depth
        $error("p_depth must be in 1..64");
    end
    if (p_thresh < 1 || p_thresh > p_depth) begin : g_bad_thresh
        $error("p_thresh must be in 1..p_depth");
    end

    logic [p_depth-1:0] window, window_next;
    logic [cw-1:0]      fill, fill_next;
    logic [cw-1:0]      count_next;
    logic               full_next;
    logic               detect_next;
    logic               oldest;

    always_comb begin
        window_next = window;
        fill_next   = fill;
        count_next  = count;
        oldest      = 1'b0;
        if (in_val) begin
            window_next    = window << 1;
            window_next[0] = in_bit;
            // Only a full window loses its oldest sample.
            oldest         = full & window[p_depth-1];
            count_next     = count + cw'(in_bit) - cw'(oldest);
            if (!full) begin
                fill_next = fill + cw'(1);
            end
        end
        full_next   = (fill_next == depth_c);
        detect_next = (count_next >= thresh_c)
                   && (full_next || !p_require_full);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            window <= '0;
            fill   <= '0;
            count  <= '0;
            full   <= 1'b0;
            detect <= 1'b0;
        end else begin
            window <= window_next;
            fill   <= fill_next;
            count  <= count_next;
            full   <= full_next;
            detect <= detect_next;
        end
    end

endmodule

// File: tb/tb_sliding_window_threshold_detector.sv
// Randomised + directed bench for four detector configurations
// driven in parallel and compared against a sample-list model.
module tb_sliding_window_threshold_detector;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic in_val = 1'b0;
    logic in_bit = 1'b0;

    logic [1:0] c0;
    logic [2:0] c1, c2;
    logic [0:0] c3;
    logic [3:0] f, d;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sliding_window_threshold_detector #(
        .p_depth(3), .p_thresh(2), .p_require_full(1'b1)
    ) u0 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_bit(in_bit),
        .clear(clear), .count(c0), .full(f[0]), .detect(d[0])
    );
    sliding_window_threshold_detector #(
        .p_depth(5), .p_thresh(3), .p_require_full(1'b1)
    ) u1 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_bit(in_bit),
        .clear(clear), .count(c1), .full(f[1]), .detect(d[1])
    );
    sliding_window_threshold_detector #(
        .p_depth(4), .p_thresh(2), .p_require_full(1'b0)
    ) u2 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_bit(in_bit),
        .clear(clear), .count(c2), .full(f[2]), .detect(d[2])
    );
    sliding_window_threshold_detector #(
        .p_depth(1), .p_thresh(1), .p_require_full(1'b1)
    ) u3 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_bit(in_bit),
        .clear(clear), .count(c3), .full(f[3]), .detect(d[3])
    );

    logic [31:0] ocnt [4];
    assign ocnt[0] = 32'(c0);
    assign ocnt[1] = 32'(c1);
    assign ocnt[2] = 32'(c2);
    assign ocnt[3] = 32'(c3);

    // Model: each config keeps its accepted samples, newest first.
    int depth  [4] = '{3, 5, 4, 1};
    int thresh [4] = '{2, 3, 2, 1};
    int reqf   [4] = '{1, 1, 0, 1};
    bit hist [4][65];
    int nfill [4] = '{0, 0, 0, 0};

    task automatic check_eq(input string tag,
                            input logic [31:0] obs,
                            input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_count(input int k);
        int s = 0;
        for (int i = 0; i < nfill[k]; i++) s += int'(hist[k][i]);
        return s;
    endfunction

    function automatic int m_full(input int k);
        return (nfill[k] == depth[k]) ? 1 : 0;
    endfunction

    function automatic int m_detect(input int k);
        return (m_count(k) >= thresh[k] && (m_full(k) == 1 || reqf[k] == 0)) ? 1 : 0;
    endfunction

    task automatic step(input logic v, input logic b,
                        input logic c, input logic r);
        @(negedge clk);
        in_val = v;
        in_bit = b;
        clear  = c;
        reset  = r;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (r || c) begin
                nfill[k] = 0;
                for (int i = 0; i < 65; i++) hist[k][i] = 1'b0;
            end else if (v) begin
                for (int i = 64; i > 0; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = b;
                if (nfill[k] < depth[k]) nfill[k]++;
            end
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("count%0d", k), ocnt[k], 32'(m_count(k)));
            check_eq($sformatf("full%0d", k), 32'(f[k]), 32'(m_full(k)));
            check_eq($sformatf("detect%0d", k), 32'(d[k]), 32'(m_detect(k)));
        end
    endtask

    task automatic feed(input logic b);
        step(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [2:0] pat;
        int e_cnt [5];
        int e_det [5];
        int s3 [8]  = '{1, 1, 0, 1, 0, 0, 1, 1};
        int c3e [8] = '{1, 2, 2, 3, 3, 2, 2, 3};
        int d3e [8] = '{0, 0, 0, 0, 1, 0, 0, 1};

        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_count", ocnt[0], 0);
        check_eq("rst_detect", 32'(d), 0);

        // Defaults: 0,1,1 then 0,0.
        e_cnt = '{0, 1, 2, 2, 1};
        e_det = '{0, 0, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            feed((i == 1 || i == 2) ? 1'b1 : 1'b0);
            check_eq("t1_count", ocnt[0], 32'(e_cnt[i]));
            check_eq("t1_detect", 32'(d[0]), 32'(e_det[i]));
        end
        check_eq("t1_full", 32'(f[0]), 1);

        // Every 3-bit pattern against majority.
        for (int p = 0; p < 8; p++) begin
            pat = 3'(p);
            flush();
            feed(pat[2]);
            feed(pat[1]);
            feed(pat[0]);
            check_eq("t2_major", 32'(d[0]), ($countones(pat) >= 2) ? 1 : 0);
        end

        flush();
        for (int i = 0; i < 8; i++) begin
            feed(1'(s3[i]));
            check_eq("t3_count", ocnt[1], 32'(c3e[i]));
            check_eq("t3_detect", 32'(d[1]), 32'(d3e[i]));
            check_eq("t3_full", 32'(f[1]), (i >= 4) ? 1 : 0);
        end

        flush();
        repeat (3) feed(1'b1);
        repeat (4) idle();
        check_eq("t4_hold_count", ocnt[0], 3);
        check_eq("t4_hold_detect", 32'(d[0]), 1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t4_clr_count", ocnt[0], 0);
        check_eq("t4_clr_full", 32'(f[0]), 0);
        check_eq("t4_clr_detect", 32'(d[0]), 0);

        flush();
        feed(1'b1);
        feed(1'b1);
        check_eq("t5_partial_det", 32'(d[2]), 1);
        check_eq("t5_partial_full", 32'(f[2]), 0);
        check_eq("t5_gated_det", 32'(d[1]), 0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("t5_rst_count", ocnt[2], 0);
        check_eq("t5_rst_detect", 32'(d), 0);

        flush();
        feed(1'b1);
        check_eq("t6_a", 32'(d[3]), 1);
        idle();
        check_eq("t6_b", 32'(d[3]), 1);
        feed(1'b0);
        check_eq("t6_c", 32'(d[3]), 0);
        idle();
        check_eq("t6_d", 32'(d[3]), 0);
        feed(1'b1);
        check_eq("t6_e", 32'(d[3]), 1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7,
                 1'($urandom),
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 199) < 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
